// File: rtl/cpu_fetch_if.sv
// rtl/cpu_fetch_if.sv - fetch unit bus: imem request/response, decode stream, redirect
interface cpu_fetch_if #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  outstanding;

  modport slave (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, outstanding,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );

  modport master (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, outstanding,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cpu_fetch_unit.sv
// rtl/cpu_fetch_unit.sv - credit-limited prefetch engine with PC-tagged instruction FIFO
module cpu_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                INST_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                PC_STEP    = 4
) (
  input logic       clk,
  input logic       rst,
  cpu_fetch_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_discard;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_tag_wr;
  logic [PTR_W-1:0]  r_tag_rd;
  logic [INST_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_tag       [FIFO_DEPTH];

  logic [CNT_W:0]    w_budget;
  logic              w_credit;
  logic              w_req_fire;
  logic              w_rsp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_pc;

  // Buffered plus in-flight never exceeds depth, so every response has a slot.
  assign w_budget      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit      = w_budget < (CNT_W+1)'(FIFO_DEPTH);
  assign w_redirect    = bus.redirect_valid;
  assign w_redirect_pc = bus.redirect_pc & ~ADDR_W'(PC_STEP - 1);

  assign bus.imem_req_valid = !rst && !w_redirect && w_credit;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign w_req_fire         = bus.imem_req_valid && bus.imem_req_ready;
  assign w_rsp              = bus.imem_rsp_valid;
  assign w_drop             = w_rsp && (w_redirect || (r_discard != '0));
  assign w_push             = w_rsp && !w_drop;

  assign bus.inst_valid  = (r_count != '0);
  assign bus.inst_data   = bus.inst_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.inst_pc     = bus.inst_valid ? r_fifo_pc[r_rd_ptr] : '0;
  assign bus.outstanding = r_outstanding;
  assign w_pop           = bus.inst_valid && bus.inst_ready && !w_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp);
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
        r_tag_wr   <= r_tag_wr + PTR_W'(1);
      end
      // The tag queue tracks every in-flight request, so it survives a flush.
      if (w_rsp) begin
        r_tag_rd <= r_tag_rd + PTR_W'(1);
      end
      if (w_redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_discard  <= r_outstanding - CNT_W'(w_rsp);
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_rsp && (r_discard != '0)) begin
          r_discard <= r_discard - CNT_W'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_tag[r_tag_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(w_rsp && (r_outstanding == '0)));

endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
- Parametrised, decoupled instruction-fetch front end for the next-generation core.
- Replaces the single-cycle PC register, +4 adder and direct instruction-memory hookup with a credit-limited prefetch engine.
- Issues sequential fetches to a latency-tolerant instruction memory and buffers returned words with their PCs in a FIFO that feeds decode.
- Supports branch redirects that flush buffered and in-flight instructions.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- INST_W, 32, instruction word width.
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, at least 2. Also the maximum number of requests in flight.
- RESET_PC, 0, PC loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch; power of two.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  ADDR_W  fetch address (current fetch_pc).
- imem_rsp_valid  input  1  response word valid. Responses return in order, at least 1 cycle after acceptance, with no backpressure.
- imem_rsp_data  input  INST_W  returned instruction.
- inst_valid  output  1  FIFO head valid toward decode.
- inst_ready  input  1  decode consumes the head.
- inst_data  output  INST_W  head instruction.
- inst_pc  output  ADDR_W  PC of the head instruction (the "old PC" used for link writes).
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  ADDR_W  redirect target. The low log2(PC_STEP) bits are forced to 0.
- outstanding  output  clog2(FIFO_DEPTH)+1  requests accepted but not yet responded to.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC.
  - FIFO empty: inst_valid=0; inst_data and inst_pc=0.
  - outstanding=0, discard_cnt=0, imem_req_valid=0.
- Credit rule:
  - imem_req_valid = !rst && !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH).
  - This guarantees every response has a free slot, so the FIFO never overflows.
- Request fire (valid && ready):
  - fetch_pc <= fetch_pc + PC_STEP, modulo 2^ADDR_W (wraps to 0 silently).
  - The request's PC is pushed into an internal pc-tag queue, in order.
- Response:
  - If discard_cnt==0: push {tag_pc, imem_rsp_data} into the FIFO.
  - Otherwise drop the word and decrement discard_cnt.
  - The tag queue pops in both cases.
- outstanding_next = outstanding + req_fire - rsp_valid. A response arriving with outstanding==0 is a protocol violation (assertion).
- Pop: inst_valid && inst_ready removes the head.
  - The head is read combinationally from storage, so a word pushed in cycle N is visible in cycle N+1.
  - Simultaneous push and pop is legal at any occupancy.
- Redirect has priority over everything in its cycle:
  - FIFO cleared; any pop that cycle is ignored.
  - No request is issued that cycle.
  - fetch_pc <= aligned redirect_pc.
  - discard_cnt <= outstanding - rsp_valid. Every word still in flight is dropped, including the one arriving that cycle.
  - First new request appears the following cycle.
  - Back-to-back redirects: each recomputes discard_cnt from the current outstanding count. The last target wins.
- Steady state with 1-cycle memory and inst_ready=1: one instruction per cycle after a 2-cycle startup.
- The memory side must be reset by the same rst. Responses to pre-reset requests must not arrive after reset deasserts.
- FIFO pointers are log2(FIFO_DEPTH) bits, wrapping; a separate count tracks full/empty.

Test Plan:
1. Reset then imem_req_ready=1, 1-cycle response, inst_ready=1 -> imem_req_addr 0,4,8,...; inst_pc 0,4,8 on consecutive cycles starting cycle 2; inst_data matches memory.
2. inst_ready=0 with FIFO_DEPTH=4 -> exactly 4 requests issued (0..C), then imem_req_valid=0; FIFO holds 4 entries; one pop re-enables exactly one request (0x10).
3. 3-cycle memory latency, redirect_valid with redirect_pc=0x103 while 2 requests are in flight and 1 is buffered -> FIFO empties; the next 2 responses are dropped; the next request is 0x100 and the first inst_pc after the redirect is 0x100.
4. Redirect in the same cycle as imem_rsp_valid and inst_ready -> the arriving word is dropped, nothing is popped, discard_cnt = outstanding-1.
5. Redirect to 0xFFFFFFFC with ADDR_W=32 -> fetches 0xFFFFFFFC then 0x00000000; inst_pc follows the same values.
6. Assert rst mid-stream with the FIFO holding 3 entries -> outputs immediately read inst_valid=0, outstanding=0; after release, fetch restarts at RESET_PC.
